spi_ram_cmd_controller: RTL and testbench

- Downstream of the SPI serial-to-parallel stage; consumes its 16-bit words plus the new_data strobe.
- Moves the SPI-domain strobe and chip select into the system clk domain.
- Decodes a header word (opcode + address), then performs writes to or reads from an internal DEPTH x 16 RAM.
- Read data is presented as tx_data/tx_valid for the MISO-side parallel-to-serial stage.

---
 rtl/spi_ram_cmd_controller_if.sv | 22 ++
 rtl/spi_ram_cmd_controller.sv | 141 ++++++++++++++
 tb/tb_spi_ram_cmd_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_cmd_controller_if.sv
// Signal bundle between the SPI shift stages and spi_ram_cmd_controller.
// tx_valid is a one-clk pulse with no back-pressure: tx_data is valid in that cycle and held until the next pulse.
interface spi_ram_cmd_controller_if;
    logic        spi_cs;
    logic [15:0] parallel_in;
    logic        new_data;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        busy;
    logic        err;
    logic [2:0]  fsm_state;

    modport master (
        output spi_cs, parallel_in, new_data,
        input  tx_data, tx_valid, busy, err, fsm_state
    );

    modport slave (
        input  spi_cs, parallel_in, new_data,
        output tx_data, tx_valid, busy, err, fsm_state
    );
endinterface

// File: rtl/spi_ram_cmd_controller.sv
// SPI command decoder and DEPTH x 16 RAM: header word (opcode + address) then write data or read-back.
// Optional macro SPI_RAM_AUTO_INC_EN enables burst writes/reads with wrapping address increment.
module spi_ram_cmd_controller #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                      clk,
    input logic                      reset,
    spi_ram_cmd_controller_if.slave  bus
);
    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [13:0] RSV_MASK = 14'h3FFF << ADDR_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_WR_DO   = 3'd3;
    localparam logic [2:0] S_RD_DO   = 3'd4;
    localparam logic [2:0] S_RD_OUT  = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;
`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [2:0] S_RD_WAIT = 3'd7;
`endif

    logic [2:0]             state;
    logic [ADDR_W-1:0]      addr;
    logic [15:0]            word_reg;
    logic [SYNC_STAGES-1:0] nd_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   nd_prev;
    logic                   cs_prev;
    logic [15:0]            tx_data_r;
    logic                   tx_valid_r;
    logic                   err_r;
    logic [15:0]            ram [DEPTH];

    logic       nd_s;
    logic       cs_s;
    logic       word_stb;
    logic       cs_fall;
    logic [1:0] opcode;
    logic       rsv_ok;

    assign nd_s     = nd_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign word_stb = nd_s & ~nd_prev;
    assign cs_fall  = cs_prev & ~cs_s;
    assign opcode   = bus.parallel_in[15:14];
    assign rsv_ok   = (bus.parallel_in[13:0] & RSV_MASK) == 14'd0;

    assign bus.tx_data   = tx_data_r;
    assign bus.tx_valid  = tx_valid_r;
    assign bus.busy      = (state != S_IDLE);
    assign bus.err       = err_r;
    assign bus.fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            word_reg   <= '0;
            nd_sync    <= '0;
            cs_sync    <= '0;
            nd_prev    <= 1'b0;
            cs_prev    <= 1'b0;
            tx_data_r  <= '0;
            tx_valid_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            nd_sync    <= {nd_sync[SYNC_STAGES-2:0], bus.new_data};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
            nd_prev    <= nd_s;
            cs_prev    <= cs_s;
            tx_valid_r <= 1'b0;
            if (word_stb) word_reg <= bus.parallel_in;

            // A deasserted chip select overrides everything, including a word arriving in the same cycle.
            if (cs_s) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state <= S_HDR;
                            err_r <= 1'b0;
                        end
                    end
                    S_HDR: begin
                        if (word_stb) begin
                            addr <= bus.parallel_in[ADDR_W-1:0];
                            if (!rsv_ok || opcode == 2'b00 || opcode == 2'b11) begin
                                err_r <= 1'b1;
                                state <= S_DRAIN;
                            end else if (opcode == 2'b01) begin
                                state <= S_WR_WAIT;
                            end else begin
                                state <= S_RD_DO;
                            end
                        end
                    end
                    S_WR_WAIT: if (word_stb) state <= S_WR_DO;
                    S_WR_DO: begin
`ifdef SPI_RAM_AUTO_INC_EN
                        addr  <= addr + ADDR_W'(1);
                        state <= S_WR_WAIT;
`else
                        state <= S_DRAIN;
`endif
                    end
                    S_RD_DO: begin
                        tx_data_r  <= ram[addr];
                        tx_valid_r <= 1'b1;
                        state      <= S_RD_OUT;
                    end
                    S_RD_OUT: begin
`ifdef SPI_RAM_AUTO_INC_EN
                        state <= S_RD_WAIT;
`else
                        state <= S_DRAIN;
`endif
                    end
`ifdef SPI_RAM_AUTO_INC_EN
                    S_RD_WAIT: begin
                        if (word_stb) begin
                            addr  <= addr + ADDR_W'(1);
                            state <= S_RD_DO;
                        end
                    end
`endif
                    S_DRAIN: state <= S_DRAIN;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // RAM contents survive reset; a write is dropped if the frame ends in the same cycle.
    always_ff @(posedge clk) begin
        if (state == S_WR_DO && !cs_s) ram[addr] <= word_reg;
    end
endmodule

// File: tb/tb_spi_ram_cmd_controller.sv
// Scoreboard bench for spi_ram_cmd_controller: random SPI frames against an array model of the RAM.
module tb_spi_ram_cmd_controller;
  localparam int ADDR_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 2 ** ADDR_W;
  // synchronizer flops, edge detect, then two clk of read pipeline
  localparam int LAT         = SYNC_STAGES + 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_ram_cmd_controller_if bus();

  spi_ram_cmd_controller #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] model_mem [DEPTH];
  bit          known [DEPTH];
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [15:0] wbuf [4];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] mon_e;
  int          mon_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every tx_valid pulse must match the oldest pending read, at the predicted cycle
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.tx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL tx_unexpected: got tx_data %0h with no read pending (cycle %0d)", bus.tx_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("tx_data", bus.tx_data, mon_e);
        check("tx_latency", cyc, mon_c);
      end
    end
  end

  // drivers: called on a negedge, return on a negedge
  task automatic cs_low();
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    bus.parallel_in = w;
    bus.new_data    = 1'b1;
    repeat (4) @(negedge clk);
    bus.new_data    = 1'b0;
    repeat ($urandom_range(4, 6)) @(negedge clk);
  endtask

  function automatic bit reads_known(input int a, input int n);
    for (int i = 0; i < n; i++) if (!known[(a + i) % DEPTH]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_write(input int a, input int n);
    cs_low();
    send_word({2'b01, 6'd0, 8'(a)});
    for (int i = 0; i < n; i++) send_word(wbuf[i]);
`ifdef SPI_RAM_AUTO_INC_EN
    for (int i = 0; i < n; i++) begin
      model_mem[(a + i) % DEPTH] = wbuf[i];
      known[(a + i) % DEPTH]     = 1'b1;
    end
`else
    model_mem[a] = wbuf[0];
    known[a]     = 1'b1;
`endif
    cs_high();
  endtask

  task automatic do_read(input int a, input int n);
    cs_low();
    exp_q.push_back(model_mem[a]);
    exp_cyc_q.push_back(cyc + LAT);
    send_word({2'b10, 6'd0, 8'(a)});
    for (int i = 1; i < n; i++) begin
`ifdef SPI_RAM_AUTO_INC_EN
      exp_q.push_back(model_mem[(a + i) % DEPTH]);
      exp_cyc_q.push_back(cyc + LAT);
`endif
      send_word(16'($urandom));
    end
    repeat (2) @(negedge clk);
    cs_high();
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish within 60000 cycles, required completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    reset           = 1'b0;
    bus.spi_cs      = 1'b1;
    bus.new_data    = 1'b0;
    bus.parallel_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_tx_data", bus.tx_data, 16'h0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_err", bus.err, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);

    // write addr 5 then read it back
    wbuf[0] = 16'hA5C3;
    do_write(5, 1);
    do_read(5, 1);
    check("rd_err", bus.err, 1'b0);

    // reset in the middle of a write: pending data word never lands
    wbuf[0] = 16'h1234;
    do_write(7, 1);
    cs_low();
    send_word(16'h4007);
    check("midwr_busy", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_tx_data", bus.tx_data, 16'h0);
    check("midrst_tx_valid", bus.tx_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_err", bus.err, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_word(16'hBEEF);
    cs_high();
    check("postrst_busy", bus.busy, 1'b0);
    do_read(7, 1);

    // illegal opcode: sticky err until next frame start
    cs_low();
    send_word(16'hC000);
    check("ill_err", bus.err, 1'b1);
    check("ill_busy", bus.busy, 1'b1);
    send_word(16'h1234);
    check("ill_err_drain", bus.err, 1'b1);
    cs_high();
    check("ill_err_after_cs", bus.err, 1'b1);
    check("ill_busy_after_cs", bus.busy, 1'b0);
    cs_low();
    check("ill_err_cleared", bus.err, 1'b0);
    check("newframe_busy", bus.busy, 1'b1);
    cs_high();

    // reserved header bit set: error, location 0 untouched
    wbuf[0] = 16'h0F0F;
    do_write(0, 1);
    cs_low();
    send_word(16'h4100);
    check("rsv_err", bus.err, 1'b1);
    send_word(16'hDEAD);
    check("rsv_err_drain", bus.err, 1'b1);
    cs_high();
    do_read(0, 1);

    // cs rises in the same synced cycle as the data word strobe
    wbuf[0] = 16'h5555;
    do_write(9, 1);
    cs_low();
    send_word(16'h4009);
    bus.parallel_in = 16'hBAD0;
    bus.new_data    = 1'b1;
    bus.spi_cs      = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    check("cs_race_busy", bus.busy, 1'b0);
    bus.new_data = 1'b0;
    repeat (4) @(negedge clk);
    do_read(9, 1);

    // burst across the top of the address space
    wbuf[0] = 16'h1111;
    wbuf[1] = 16'h2222;
    do_write(8'hFF, 2);
    do_read(8'hFF, 2);
    do_read(0, 1);

    // randomized traffic in a window that straddles the wrap point
    for (int t = 0; t < 30; t++) begin
      int a;
      int n;
      a = (250 + $urandom_range(0, 11)) % DEPTH;
`ifdef SPI_RAM_AUTO_INC_EN
      n = $urandom_range(1, 3);
`else
      n = $urandom_range(1, 2);
`endif
      if ($urandom_range(0, 1) == 1 && reads_known(a, n)) begin
        do_read(a, n);
      end else begin
        for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
        do_write(a, n);
      end
    end

    repeat (10) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("final_err", bus.err, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
